wptr_full_ctrl: RTL and testbench
=================================

Name: wptr_full_ctrl

Overview:
- Write-side pointer and flag generator for the asynchronous FIFO, in the write clock domain.
- Drives the Gray-coded write pointer into the write-to-read pointer synchronizer.
- Consumes the read pointer after it has been synchronized into the write domain.
- Produces the memory write address, write accept, full/almost-full flags, fill level and a sticky overflow error.

Parameters:
- PTR_WIDTH, 3, address width; FIFO depth = 2**PTR_WIDTH; pointers are PTR_WIDTH+1 bits (extra MSB for wrap detection).
- AF_THRESH, 6, fill level at or above which almost_full asserts; legal range 1..2**PTR_WIDTH.

Ports:
- clk  input  1  write-domain clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- w_en  input  1  write request from producer.
- ovf_clr  input  1  clears the sticky overflow flag.
- rptr_sync  input  PTR_WIDTH+1  Gray read pointer, already synchronized into clk domain.
- w_accept  output  1  combinational w_en & ~full; memory write enable.
- waddr  output  PTR_WIDTH  memory write address = wbin[PTR_WIDTH-1:0].
- wptr  output  PTR_WIDTH+1  registered Gray write pointer, to synchronizer.
- full  output  1  registered full flag.
- almost_full  output  1  registered, wlevel >= AF_THRESH.
- wlevel  output  PTR_WIDTH+1  registered write-side fill count, 0..2**PTR_WIDTH.
- overflow  output  1  sticky: a write was attempted while full.

Behaviour:
- Reset (rst=1 at a clk edge): wbin, wptr, wlevel = 0; full, almost_full, overflow = 0. Reset overrides w_en and ovf_clr. w_accept is 0 while full=0 is forced.
- Internal binary pointer wbin (PTR_WIDTH+1 bits). wbin_next = wbin + w_accept, modulo 2**(PTR_WIDTH+1), wrapping naturally.
- wgray_next = wbin_next ^ (wbin_next >> 1). wptr <= wgray_next every cycle. Only one bit of wptr changes per cycle, which the synchronizer relies on; wptr never comes from combinational logic.
- full <= (wgray_next == {~rptr_sync[PTR_WIDTH:PTR_WIDTH-1], rptr_sync[PTR_WIDTH-2:0]}).
  - full updates in the same edge as the pointer, so the write that fills the FIFO makes full=1 on the next cycle.
- rbin_sync = Gray-to-binary of rptr_sync (combinational XOR prefix).
- wlevel <= wbin_next - rbin_sync, modulo 2**(PTR_WIDTH+1).
- almost_full <= ((wbin_next - rbin_sync) >= AF_THRESH).
- Deassertion is pessimistic by design: rptr_sync lags the true read pointer by 2+ cycles, so full, almost_full and wlevel may overstate occupancy. This is never optimistic; no correction is attempted.
- Write while full: w_accept=0, wbin and wptr hold, overflow <= 1.
- Overflow clear: ovf_clr=1 with no overflowing write in the same cycle clears overflow. Set wins over clear when both occur in the same cycle.
- Full exit: if rptr_sync advances in the same cycle as a blocked write, the write stays blocked. full drops on the next edge and a new write can be accepted the cycle after.
- Latency: w_en to wptr update is 1 cycle; rptr_sync change to full/wlevel update is 1 cycle.
- No FSM. The block is a counter plus registered compare and arithmetic.

Decomposition:
- Shared fifo package holds:
  - default PTR_WIDTH constant;
  - bin2gray and gray2bin functions, parameterized width, reused by the read-side controller.
- No sub-module. Gray conversion is done through the package functions.
- The mirror read-side block (rptr_empty_ctrl) is a separate future module and is out of scope.

Test Plan:
- Reset: rst=1 for 2 cycles with w_en=1 and rptr_sync=4'b0110 -> wptr=0000, waddr=0, full=0, almost_full=0, wlevel=0, overflow=0, no write accepted.
- Fill (rptr_sync=0000, w_en=1 for 8 cycles):
  - waddr runs 0..7;
  - wptr steps 0001,0011,0010,0110,0111,0101,0100,1100;
  - almost_full=1 after the 6th accept;
  - full=1 after the 8th accept, with wlevel=8.
- Overflow: hold w_en=1 for 3 more cycles while full -> w_accept=0, wptr stays 1100, overflow=1 and stays 1. Pulse ovf_clr=1 for 1 cycle -> overflow=0.
- Drain: while full, rptr_sync 0000->0001 -> next cycle full=0, wlevel=7. The next w_en is accepted at waddr=0 and full reasserts (wptr 1101).
- Wrap: 20 writes with rptr_sync tracking 2 entries behind -> wbin wraps 1111->0000 (wptr 1000->0000), full never asserts, wlevel stays 2.
- Mid-operation reset: after 5 accepted writes, assert rst for 1 cycle with w_en=1 -> next cycle wptr=0000, waddr=0, wlevel=0, flags 0; write in the reset cycle not counted.

Source files
------------

// File: rtl/wptr_full_ctrl_pkg.sv
// ============================================================================
// wptr_full_ctrl_pkg : shared async-FIFO constants and Gray-code helpers
// Rev 1.0
// ============================================================================
`default_nettype none

package wptr_full_ctrl_pkg;

  localparam int DEF_PTR_WIDTH = 3;

  // Helpers work on a wide word; callers zero-extend in and cast back to size.
  localparam int GRAY_MAX_W = 32;
  typedef logic [GRAY_MAX_W-1:0] gray_word_t;

  function automatic gray_word_t bin2gray(input gray_word_t b);
    return b ^ (b >> 1);
  endfunction

  function automatic gray_word_t gray2bin(input gray_word_t g);
    gray_word_t b;
    b[GRAY_MAX_W-1] = g[GRAY_MAX_W-1];
    for (int i = GRAY_MAX_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

`default_nettype wire

// File: rtl/wptr_full_ctrl.sv
// ============================================================================
// wptr_full_ctrl : async-FIFO write pointer, full/almost-full, level, overflow
// Rev 1.0
// ============================================================================
`default_nettype none

module wptr_full_ctrl
  import wptr_full_ctrl_pkg::*;
#(
  parameter int PTR_WIDTH = DEF_PTR_WIDTH,
  parameter int AF_THRESH = 6
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 w_en,
  input  logic                 ovf_clr,
  input  logic [PTR_WIDTH:0]   rptr_sync,
  output logic                 w_accept,
  output logic [PTR_WIDTH-1:0] waddr,
  output logic [PTR_WIDTH:0]   wptr,
  output logic                 full,
  output logic                 almost_full,
  output logic [PTR_WIDTH:0]   wlevel,
  output logic                 overflow
);

  localparam int                 PW          = PTR_WIDTH + 1;
  localparam logic [PTR_WIDTH:0] c_af_thresh = PW'(AF_THRESH);

  logic [PTR_WIDTH:0] r_wbin;
  logic [PTR_WIDTH:0] w_wbin_next;
  logic [PTR_WIDTH:0] w_wgray_next;
  logic [PTR_WIDTH:0] w_rbin_sync;
  logic [PTR_WIDTH:0] w_level_next;
  logic [PTR_WIDTH:0] w_full_gray;

  // No write is taken in a reset cycle, so the pointer never counts it.
  assign w_accept     = w_en & ~full & ~rst;
  assign waddr        = r_wbin[PTR_WIDTH-1:0];

  assign w_wbin_next  = r_wbin + {{PTR_WIDTH{1'b0}}, w_accept};
  assign w_wgray_next = PW'(bin2gray(gray_word_t'(w_wbin_next)));
  assign w_rbin_sync  = PW'(gray2bin(gray_word_t'(rptr_sync)));
  assign w_level_next = w_wbin_next - w_rbin_sync;

  // Write pointer is one lap ahead of read: top two Gray bits inverted.
  assign w_full_gray  = {~rptr_sync[PTR_WIDTH:PTR_WIDTH-1], rptr_sync[PTR_WIDTH-2:0]};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wbin      <= '0;
      wptr        <= '0;
      full        <= 1'b0;
      almost_full <= 1'b0;
      wlevel      <= '0;
      overflow    <= 1'b0;
    end else begin
      r_wbin      <= w_wbin_next;
      wptr        <= w_wgray_next;
      full        <= (w_wgray_next == w_full_gray);
      almost_full <= (w_level_next >= c_af_thresh);
      wlevel      <= w_level_next;
      if (w_en & full) begin
        overflow <= 1'b1;
      end else if (ovf_clr) begin
        overflow <= 1'b0;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_wptr_full_ctrl.sv
// ============================================================================
// tb_wptr_full_ctrl : directed + random check against a count-based model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_wptr_full_ctrl;

  localparam int PW    = 3;
  localparam int DEPTH = 8;
  localparam int AF    = 6;

  logic          clk = 1'b0;
  logic          rst;
  logic          w_en;
  logic          ovf_clr;
  logic [PW:0]   rptr_sync;
  logic          w_accept;
  logic [PW-1:0] waddr;
  logic [PW:0]   wptr;
  logic          full;
  logic          almost_full;
  logic [PW:0]   wlevel;
  logic          overflow;

  wptr_full_ctrl #(.PTR_WIDTH(PW), .AF_THRESH(AF)) dut (
    .clk        (clk),
    .rst        (rst),
    .w_en       (w_en),
    .ovf_clr    (ovf_clr),
    .rptr_sync  (rptr_sync),
    .w_accept   (w_accept),
    .waddr      (waddr),
    .wptr       (wptr),
    .full       (full),
    .almost_full(almost_full),
    .wlevel     (wlevel),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // Model: total writes accepted and total reads seen, as plain integers.
  int wcount = 0;
  int rcount = 0;
  int m_lvl  = 0;
  bit m_full = 1'b0;
  bit m_af   = 1'b0;
  bit m_ovf  = 1'b0;
  int rs_override = -1;

  function automatic logic [PW:0] gray_of(input int n);
    int m;
    m = n % (2 * DEPTH);
    return (PW+1)'(m ^ (m >> 1));
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_regs();
    chk("wptr",        32'(wptr),        32'(gray_of(wcount)));
    chk("waddr",       32'(waddr),       32'(wcount % DEPTH));
    chk("wlevel",      32'(wlevel),      32'(m_lvl));
    chk("full",        32'(full),        32'(m_full));
    chk("almost_full", 32'(almost_full), 32'(m_af));
    chk("overflow",    32'(overflow),    32'(m_ovf));
  endtask

  task automatic cycle(input bit r, input bit we, input bit clr);
    bit exp_acc;
    rst       = r;
    w_en      = we;
    ovf_clr   = clr;
    rptr_sync = (rs_override >= 0) ? (PW+1)'(rs_override) : gray_of(rcount);
    #1;
    exp_acc = !r && we && !m_full;
    chk("w_accept", 32'(w_accept), 32'(exp_acc));
    @(posedge clk);
    #1;
    if (r) begin
      wcount = 0;
      m_lvl  = 0;
      m_full = 1'b0;
      m_af   = 1'b0;
      m_ovf  = 1'b0;
    end else begin
      if (exp_acc) wcount++;
      if (we && m_full) m_ovf = 1'b1;
      else if (clr)     m_ovf = 1'b0;
      m_lvl  = wcount - rcount;
      m_full = (m_lvl == DEPTH);
      m_af   = (m_lvl >= AF);
    end
    check_regs();
  endtask

  initial begin
    // Reset with a non-zero read pointer and a pending write
    rs_override = 6;
    cycle(1'b1, 1'b1, 1'b0);
    cycle(1'b1, 1'b1, 1'b0);
    rs_override = -1;
    rcount = 0;

    // Fill
    for (int i = 0; i < DEPTH; i++) begin
      cycle(1'b0, 1'b1, 1'b0);
      if (i == AF - 2) chk("af_before_6th", 32'(almost_full), 32'd0);
      if (i == AF - 1) chk("af_after_6th",  32'(almost_full), 32'd1);
    end
    chk("fill_wptr",   32'(wptr),   32'b1100);
    chk("fill_full",   32'(full),   32'd1);
    chk("fill_wlevel", 32'(wlevel), 32'd8);

    // Overflow while full, then clear
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 1'b1, 1'b0);
      chk("ovf_wptr_hold", 32'(wptr),     32'b1100);
      chk("ovf_sticky",    32'(overflow), 32'd1);
    end
    cycle(1'b0, 1'b0, 1'b1);
    chk("ovf_cleared", 32'(overflow), 32'd0);

    // Set wins over clear
    cycle(1'b0, 1'b1, 1'b1);
    chk("ovf_set_wins", 32'(overflow), 32'd1);
    cycle(1'b0, 1'b0, 1'b1);

    // Drain one entry, then refill
    rcount = 1;
    cycle(1'b0, 1'b0, 1'b0);
    chk("drain_full",   32'(full),   32'd0);
    chk("drain_wlevel", 32'(wlevel), 32'd7);
    cycle(1'b0, 1'b1, 1'b0);
    chk("refill_wptr", 32'(wptr), 32'b1101);
    chk("refill_full", 32'(full), 32'd1);

    // Wrap with the reader two entries behind
    rcount = wcount - 2;
    cycle(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      rcount = wcount - 1;
      cycle(1'b0, 1'b1, 1'b0);
      chk("wrap_level", 32'(wlevel), 32'd2);
      chk("wrap_full",  32'(full),   32'd0);
    end

    // Random traffic
    for (int i = 0; i < 300; i++) begin
      bit we;
      bit clr;
      if ($urandom_range(0, 2) != 0 && rcount < wcount) begin
        rcount += (wcount - rcount >= 2) ? int'($urandom_range(1, 2)) : 1;
      end
      we  = ($urandom_range(0, 9) < 7);
      clr = ($urandom_range(0, 7) == 0);
      cycle(1'b0, we, clr);
    end

    // Mid-operation reset after five accepted writes
    rcount = wcount;
    cycle(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, 1'b0);
    rcount = 0;
    cycle(1'b1, 1'b1, 1'b0);
    chk("midrst_wptr",   32'(wptr),   32'd0);
    chk("midrst_waddr",  32'(waddr),  32'd0);
    chk("midrst_wlevel", 32'(wlevel), 32'd0);
    cycle(1'b0, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
